// File: rtl/gray_pkg.sv
// Shared helpers for the binary/Gray counter family.
// Functions use a 32-bit carrier, so counters up to 32 bits wide are covered.
package gray_pkg;

  localparam int unsigned GRAY_MAX_WIDTH = 32;

  // Reflected binary code of a binary value.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Largest count representable in 'width' bits (2^width - 1).
  function automatic logic [GRAY_MAX_WIDTH-1:0] count_max(input int unsigned width);
    if (width >= GRAY_MAX_WIDTH) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray converter; mirror of gray_to_binary.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  // Widen into the package carrier and cut back to WIDTH bits.
  assign o_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(i_bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Registered binary/Gray up-down counter with optional wrap or saturation.
// Both the binary and the Gray count come straight from flops; the Gray value
// is always derived from the next binary value so the two never diverge.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(count_max(WIDTH));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;

  // Next-state selection: load beats en, en beats hold; wrap is a one-cycle pulse.
  always_comb begin
    w_bin_nxt  = r_bin;
    w_wrap_nxt = 1'b0;
    w_sat_nxt  = r_sat;
    if (load) begin
      w_bin_nxt = load_val;
      w_sat_nxt = 1'b0;
    end else if (en) begin
      if (up_dn) begin
        if (r_bin != MAX) begin
          w_bin_nxt = r_bin + ONE;
          w_sat_nxt = 1'b0;
        end else if (WRAP_EN) begin
          w_bin_nxt  = '0;
          w_wrap_nxt = 1'b1;
          w_sat_nxt  = 1'b0;
        end else begin
          w_sat_nxt = 1'b1;
        end
      end else begin
        if (r_bin != '0) begin
          w_bin_nxt = r_bin - ONE;
          w_sat_nxt = 1'b0;
        end else if (WRAP_EN) begin
          w_bin_nxt  = MAX;
          w_wrap_nxt = 1'b1;
          w_sat_nxt  = 1'b0;
        end else begin
          w_sat_nxt = 1'b1;
        end
      end
    end
  end

  bin_to_gray #(
    .WIDTH (WIDTH)
  ) u_bin_to_gray (
    .i_bin  (w_bin_nxt),
    .o_gray (w_gray_nxt)
  );

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_wrap <= w_wrap_nxt;
      r_sat  <= w_sat_nxt;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign sat      = r_sat;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed and randomized checks of gray_code_counter in three configurations:
// 4-bit wrapping (a), 4-bit saturating (b) and 8-bit wrapping (c).
module tb_gray_code_counter;

  logic clk;
  logic rst_n, en, up_dn, load;
  logic [3:0] lv4;
  logic [3:0] a_gray, a_bin, b_gray, b_bin;
  logic a_wrap, a_sat, b_wrap, b_sat;

  logic c_rst_n, c_en, c_up, c_load;
  logic [7:0] c_lv, c_gray, c_bin;
  logic c_wrap, c_sat;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_code_counter #(.WIDTH(4), .WRAP_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .gray_out(a_gray), .bin_out(a_bin), .wrap(a_wrap), .sat(a_sat));

  gray_code_counter #(.WIDTH(4), .WRAP_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .gray_out(b_gray), .bin_out(b_bin), .wrap(b_wrap), .sat(b_sat));

  gray_code_counter #(.WIDTH(8), .WRAP_EN(1'b1)) u_c (
    .clk(clk), .rst_n(c_rst_n), .en(c_en), .up_dn(c_up), .load(c_load), .load_val(c_lv),
    .gray_out(c_gray), .bin_out(c_bin), .wrap(c_wrap), .sat(c_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray-to-binary decode, the role gray_to_binary plays downstream.
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  // Decoded Gray must equal the binary shadow on every cycle.
  always @(negedge clk) begin
    n_total++;
    if (g2b({4'd0, a_gray}) !== {4'd0, a_bin}) $display("FAIL inv_a: gray %b decodes to %0d, bin_out %0d", a_gray, g2b({4'd0, a_gray}), a_bin); else n_pass++;
    n_total++;
    if (g2b({4'd0, b_gray}) !== {4'd0, b_bin}) $display("FAIL inv_b: gray %b decodes to %0d, bin_out %0d", b_gray, g2b({4'd0, b_gray}), b_bin); else n_pass++;
    n_total++;
    if (g2b(c_gray) !== c_bin) $display("FAIL inv_c: gray %b decodes to %0d, bin_out %0d", c_gray, g2b(c_gray), c_bin); else n_pass++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; lv4 = 4'd7;
    c_rst_n = 1'b0; c_en = 1'b0; c_up = 1'b0; c_load = 1'b0; c_lv = 8'd0;
    step();
    n_total++;
    if ({a_bin, a_gray, a_wrap, a_sat} !== 10'd0) $display("FAIL reset_a: got bin %0d gray %b wrap %b sat %b, expected all zero", a_bin, a_gray, a_wrap, a_sat); else n_pass++;
    n_total++;
    if ({b_bin, b_gray, b_wrap, b_sat} !== 10'd0) $display("FAIL reset_b: got bin %0d gray %b wrap %b sat %b, expected all zero", b_bin, b_gray, b_wrap, b_sat); else n_pass++;
    n_total++;
    if ({c_bin, c_gray, c_wrap, c_sat} !== 18'd0) $display("FAIL reset_c: got bin %0d gray %b wrap %b sat %b, expected all zero", c_bin, c_gray, c_wrap, c_sat); else n_pass++;
    rst_n = 1'b1; c_rst_n = 1'b1; en = 1'b0; load = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      prev = a_gray;
      step();
      n_total++;
      if (a_gray !== gtab[i % 16]) $display("FAIL up_gray[%0d]: got %b expected %b", i, a_gray, gtab[i % 16]); else n_pass++;
      n_total++;
      if ($countones(prev ^ a_gray) != 1) $display("FAIL up_onebit[%0d]: %b -> %b flips %0d bits, expected 1", i, prev, a_gray, $countones(prev ^ a_gray)); else n_pass++;
      n_total++;
      if (a_wrap !== (i == 16)) $display("FAIL up_wrap[%0d]: got %b expected %b", i, a_wrap, (i == 16)); else n_pass++;
    end
    n_total++;
    if (b_bin !== 4'd15 || b_sat !== 1'b1) $display("FAIL up_b_sat: got bin %0d sat %b expected bin 15 sat 1", b_bin, b_sat); else n_pass++;
    en = 1'b0;
    step();
    n_total++;
    if (a_wrap !== 1'b0 || a_bin !== 4'd0) $display("FAIL wrap_pulse: got wrap %b bin %0d expected wrap 0 bin 0", a_wrap, a_bin); else n_pass++;
  endtask

  task automatic test_count_down();
    en = 1'b1; up_dn = 1'b0;
    step();
    n_total++;
    if ({a_bin, a_gray, a_wrap} !== {4'd15, 4'b1000, 1'b1}) $display("FAIL down_wrap: got bin %0d gray %b wrap %b expected 15 1000 1", a_bin, a_gray, a_wrap); else n_pass++;
    step();
    n_total++;
    if ({a_bin, a_gray, a_wrap} !== {4'd14, 4'b1001, 1'b0}) $display("FAIL down_next: got bin %0d gray %b wrap %b expected 14 1001 0", a_bin, a_gray, a_wrap); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; lv4 = 4'd10; en = 1'b1; up_dn = 1'b1;
    step();
    n_total++;
    if ({a_bin, a_gray, a_wrap, a_sat} !== {4'd10, 4'b1111, 1'b0, 1'b0}) $display("FAIL load_wins: got bin %0d gray %b wrap %b sat %b expected 10 1111 0 0", a_bin, a_gray, a_wrap, a_sat); else n_pass++;
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({a_bin, a_gray, a_wrap} !== {4'd10, 4'b1111, 1'b0}) $display("FAIL hold[%0d]: got bin %0d gray %b wrap %b expected 10 1111 0", i, a_bin, a_gray, a_wrap); else n_pass++;
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; lv4 = 4'd15; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    n_total++;
    if ({b_bin, b_sat, b_wrap} !== {4'd15, 1'b1, 1'b0}) $display("FAIL sat_up: got bin %0d sat %b wrap %b expected 15 1 0", b_bin, b_sat, b_wrap); else n_pass++;
    en = 1'b0;
    step();
    n_total++;
    if ({b_bin, b_sat} !== {4'd15, 1'b1}) $display("FAIL sat_hold: got bin %0d sat %b expected 15 1", b_bin, b_sat); else n_pass++;
    en = 1'b1; up_dn = 1'b0;
    step();
    n_total++;
    if ({b_bin, b_gray, b_sat} !== {4'd14, 4'b1001, 1'b0}) $display("FAIL sat_down: got bin %0d gray %b sat %b expected 14 1001 0", b_bin, b_gray, b_sat); else n_pass++;
    load = 1'b1; lv4 = 4'd0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step();
    n_total++;
    if ({b_bin, b_sat, b_wrap} !== {4'd0, 1'b1, 1'b0}) $display("FAIL sat_zero: got bin %0d sat %b wrap %b expected 0 1 0", b_bin, b_sat, b_wrap); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; lv4 = 4'd0;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_dn = i[0];
      step();
      n_total++;
      if ({a_bin, a_wrap} !== {(i[0] ? 4'd0 : 4'd15), 1'b1}) $display("FAIL b2b_wrap[%0d]: got bin %0d wrap %b expected %0d 1", i, a_bin, a_wrap, (i[0] ? 4'd0 : 4'd15)); else n_pass++;
    end
    en = 1'b0;
    step();
    n_total++;
    if (a_wrap !== 1'b0) $display("FAIL b2b_end: got wrap %b expected 0", a_wrap); else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    step();
    rst_n = 1'b1; load = 1'b1; lv4 = 4'd15;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_total++;
    if ({a_bin, a_gray} !== {4'd6, 4'b0101}) $display("FAIL mid_count: got bin %0d gray %b expected 6 0101", a_bin, a_gray); else n_pass++;
    n_total++;
    if ({b_bin, b_sat} !== {4'd15, 1'b1}) $display("FAIL mid_b_sat: got bin %0d sat %b expected 15 1", b_bin, b_sat); else n_pass++;
    rst_n = 1'b0; load = 1'b1; lv4 = 4'd9; en = 1'b1;
    step();
    n_total++;
    if ({a_bin, a_gray, a_wrap, a_sat} !== 10'd0) $display("FAIL mid_reset_a: got bin %0d gray %b wrap %b sat %b expected all zero", a_bin, a_gray, a_wrap, a_sat); else n_pass++;
    n_total++;
    if ({b_bin, b_sat} !== 5'd0) $display("FAIL mid_reset_b: got bin %0d sat %b expected 0 0", b_bin, b_sat); else n_pass++;
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] m_bin;
    logic m_wrap, m_sat, stepped;
    logic [7:0] prev_gray, exp_gray;
    logic [31:0] r;
    m_bin = c_bin === 8'd0 ? 8'd0 : 8'd0;
    m_wrap = 1'b0; m_sat = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      r = $urandom;
      c_rst_n = (r[7:0] != 8'd0);
      c_load  = (r[11:8] == 4'd0);
      c_en    = (r[13:12] != 2'd0);
      c_up    = r[14];
      c_lv    = r[23:16];
      stepped = 1'b0;
      if (!c_rst_n) begin
        m_bin = 8'd0; m_wrap = 1'b0; m_sat = 1'b0;
      end else if (c_load) begin
        m_bin = c_lv; m_wrap = 1'b0; m_sat = 1'b0;
      end else if (c_en) begin
        stepped = 1'b1; m_sat = 1'b0;
        m_wrap = c_up ? (m_bin == 8'hFF) : (m_bin == 8'h00);
        m_bin  = c_up ? m_bin + 8'd1 : m_bin - 8'd1;
      end else begin
        m_wrap = 1'b0;
      end
      exp_gray = m_bin ^ (m_bin >> 1);
      prev_gray = c_gray;
      step();
      n_total++;
      if ({c_bin, c_gray} !== {m_bin, exp_gray}) $display("FAIL rnd_count[%0d]: got bin %0d gray %b expected %0d %b", i, c_bin, c_gray, m_bin, exp_gray); else n_pass++;
      n_total++;
      if ({c_wrap, c_sat} !== {m_wrap, m_sat}) $display("FAIL rnd_flags[%0d]: got wrap %b sat %b expected %b %b", i, c_wrap, c_sat, m_wrap, m_sat); else n_pass++;
      if (stepped) begin
        n_total++;
        if ($countones(prev_gray ^ c_gray) != 1) $display("FAIL rnd_onebit[%0d]: %b -> %b flips %0d bits, expected 1", i, prev_gray, c_gray, $countones(prev_gray ^ c_gray)); else n_pass++;
      end
    end
    c_en = 1'b0; c_load = 1'b0; c_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_saturate();
    test_back_to_back();
    test_reset_mid_count();
    test_random();
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
